// File: rtl/multicycle_control.sv
// Moore sequencer for a multi-cycle LEGv8 datapath (shared ALU, unified memory).
// 3-5 cycles per instruction; FETCH/MEMRD/MEMWR stall in place while MemReady is low.
module multicycle_control #(
    parameter int STATE_W = 4
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic [10:0]        Opcode,
    input  logic               Zero,
    input  logic               MemReady,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               IRWrite,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IorD,
    output logic               RegWrite,
    output logic               MemtoReg,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ALUOp,
    output logic               PCSource,
    output logic               Illegal,
    output logic [STATE_W-1:0] State
);

    typedef enum logic [STATE_W-1:0] {
        S_FETCH   = STATE_W'(0),
        S_DECODE  = STATE_W'(1),
        S_EXEC_R  = STATE_W'(2),
        S_EXEC_I  = STATE_W'(3),
        S_ALU_WB  = STATE_W'(4),
        S_MEMADR  = STATE_W'(5),
        S_MEMRD   = STATE_W'(6),
        S_MEMWR   = STATE_W'(7),
        S_MEM_WB  = STATE_W'(8),
        S_CBZ     = STATE_W'(9),
        S_BR      = STATE_W'(10),
        S_ILLEGAL = STATE_W'(11)
    } state_t;

    localparam logic [10:0] OP_LDUR = 11'b111_1100_0010;
    localparam logic [10:0] OP_STUR = 11'b111_1100_0000;
    localparam logic [10:0] OP_ADD  = 11'b100_0101_1000;
    localparam logic [10:0] OP_SUB  = 11'b110_0101_1000;
    localparam logic [10:0] OP_AND  = 11'b100_0101_0000;
    localparam logic [10:0] OP_ORR  = 11'b101_0101_0000;
    localparam logic [10:0] OP_LSL  = 11'b110_1001_1011;

    state_t state_q;
    state_t state_d;
    state_t decode_tgt;

    // Pre-gating strobes; Reset forces them low at the ports.
    logic pc_write;
    logic pc_write_cond;
    logic ir_write;
    logic mem_read;
    logic mem_write;
    logic reg_write;
    logic illegal;

    // The branch decision is taken in the datapath from Zero and PCWriteCond.
    logic unused_zero;
    assign unused_zero = Zero;

    always_comb begin
        decode_tgt = S_ILLEGAL;
        if ((Opcode == OP_LDUR) || (Opcode == OP_STUR)) begin
            decode_tgt = S_MEMADR;
        end else if (Opcode[10:3] == 8'b1011_0100) begin
            decode_tgt = S_CBZ;
        end else if (Opcode[10:5] == 6'b000101) begin
            decode_tgt = S_BR;
        end else if ((Opcode == OP_ADD) || (Opcode == OP_SUB) || (Opcode == OP_AND) ||
                     (Opcode == OP_ORR) || (Opcode == OP_LSL)) begin
            decode_tgt = S_EXEC_R;
        end else if (Opcode[10:1] == 10'b10_1100_1000) begin
            decode_tgt = S_EXEC_I;
        end
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:   state_d = MemReady ? S_DECODE : S_FETCH;
            S_DECODE:  state_d = decode_tgt;
            S_EXEC_R:  state_d = S_ALU_WB;
            S_EXEC_I:  state_d = S_ALU_WB;
            S_ALU_WB:  state_d = S_FETCH;
            // IR is frozen outside FETCH, so Opcode[1] still tells LDUR from STUR.
            S_MEMADR:  state_d = Opcode[1] ? S_MEMRD : S_MEMWR;
            S_MEMRD:   state_d = MemReady ? S_MEM_WB : S_MEMRD;
            S_MEMWR:   state_d = MemReady ? S_FETCH : S_MEMWR;
            S_MEM_WB:  state_d = S_FETCH;
            S_CBZ:     state_d = S_FETCH;
            S_BR:      state_d = S_FETCH;
            S_ILLEGAL: state_d = S_FETCH;
            default:   state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        ir_write      = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        reg_write     = 1'b0;
        illegal       = 1'b0;
        IorD          = 1'b0;
        MemtoReg      = 1'b0;
        ALUSrcA       = 1'b0;
        ALUSrcB       = 2'b00;
        ALUOp         = 2'b00;
        PCSource      = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read = 1'b1;
                ALUSrcB  = 2'b01;
                // IR and PC+4 latch on the same edge the memory delivers.
                ir_write = MemReady;
                pc_write = MemReady;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
            end
            S_EXEC_R: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b00;
                ALUOp   = 2'b10;
            end
            S_EXEC_I: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUOp   = 2'b10;
            end
            S_ALU_WB: begin
                reg_write = 1'b1;
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                IorD     = 1'b1;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                IorD      = 1'b1;
            end
            S_MEM_WB: begin
                reg_write = 1'b1;
                MemtoReg  = 1'b1;
            end
            S_CBZ: begin
                ALUSrcA       = 1'b1;
                ALUSrcB       = 2'b00;
                ALUOp         = 2'b01;
                pc_write_cond = 1'b1;
                PCSource      = 1'b1;
            end
            S_BR: begin
                pc_write = 1'b1;
                PCSource = 1'b1;
            end
            S_ILLEGAL: begin
                illegal = 1'b1;
            end
            default: begin
                pc_write = 1'b0;
            end
        endcase
    end

    assign PCWrite     = pc_write & ~Reset;
    assign PCWriteCond = pc_write_cond & ~Reset;
    assign IRWrite     = ir_write & ~Reset;
    assign MemRead     = mem_read & ~Reset;
    assign MemWrite    = mem_write & ~Reset;
    assign RegWrite    = reg_write & ~Reset;
    assign Illegal     = illegal & ~Reset;
    assign State       = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction expected control traces built from opcode class.
module tb_multicycle_control;

    logic        CLK = 1'b0;
    logic        Reset;
    logic [10:0] Opcode;
    logic        Zero;
    logic        MemReady;
    logic        PCWrite, PCWriteCond, IRWrite, MemRead, MemWrite, IorD;
    logic        RegWrite, MemtoReg, ALUSrcA, PCSource, Illegal;
    logic [1:0]  ALUSrcB, ALUOp;
    logic [3:0]  State;

    multicycle_control #(.STATE_W(4)) dut (
        .CLK(CLK), .Reset(Reset), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IRWrite(IRWrite),
        .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD), .RegWrite(RegWrite),
        .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .Illegal(Illegal), .State(State)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    logic [14:0] obs;
    assign obs = {PCWrite, PCWriteCond, IRWrite, MemRead, MemWrite, IorD, RegWrite,
                  MemtoReg, ALUSrcA, ALUSrcB, ALUOp, PCSource, Illegal};

    task automatic check_ctl(input string tag, input logic [14:0] got, input logic [14:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [14:0] v(input logic pcw, input logic pcwc, input logic irw,
                                      input logic mr, input logic mw, input logic iord,
                                      input logic rw, input logic m2r, input logic srca,
                                      input logic [1:0] srcb, input logic [1:0] aluop,
                                      input logic pcsrc, input logic ill);
        return {pcw, pcwc, irw, mr, mw, iord, rw, m2r, srca, srcb, aluop, pcsrc, ill};
    endfunction

    typedef enum {K_LD, K_ST, K_CBZ, K_B, K_R, K_I, K_ILL} kind_t;

    function automatic kind_t classify(input logic [10:0] op);
        if (op == 11'b111_1100_0010) return K_LD;
        if (op == 11'b111_1100_0000) return K_ST;
        if (op[10:3] == 8'b1011_0100) return K_CBZ;
        if (op[10:5] == 6'b000101) return K_B;
        if (op == 11'b100_0101_1000 || op == 11'b110_0101_1000 || op == 11'b100_0101_0000 ||
            op == 11'b101_0101_0000 || op == 11'b110_1001_1011) return K_R;
        if (op[10:1] == 10'b10_1100_1000) return K_I;
        return K_ILL;
    endfunction

    typedef struct {
        logic        rdy;
        logic [14:0] vec;
        string       tag;
    } step_t;

    step_t q[$];

    task automatic push(input logic rdy, input logic [14:0] vec, input string tag);
        step_t s;
        s.rdy = rdy;
        s.vec = vec;
        s.tag = tag;
        q.push_back(s);
    endtask

    function automatic logic rnd_bit();
        return logic'($urandom_range(0, 1));
    endfunction

    // Expected control words per role in the instruction sequence.
    function automatic logic [14:0] e_fetch(input logic rdy);
        return v(rdy, 0, rdy, 1, 0, 0, 0, 0, 0, 2'b01, 2'b00, 0, 0);
    endfunction
    function automatic logic [14:0] e_reset();
        return v(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 0, 0);
    endfunction

    // Must be called shortly after a rising edge with the DUT sitting in FETCH.
    task automatic run_instr(input logic [10:0] op, input logic z, input int fw, input int mw);
        kind_t k;
        k = classify(op);
        q.delete();
        for (int i = 0; i < fw; i++) push(1'b0, e_fetch(1'b0), "fetch_wait");
        push(1'b1, e_fetch(1'b1), "fetch");
        push(rnd_bit(), v(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 0, 0), "decode");
        case (k)
            K_R: begin
                push(rnd_bit(), v(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 0, 0), "exec_r");
                push(rnd_bit(), v(0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 0, 0), "alu_wb");
            end
            K_I: begin
                push(rnd_bit(), v(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b10, 0, 0), "exec_i");
                push(rnd_bit(), v(0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 0, 0), "alu_wb");
            end
            K_LD: begin
                push(rnd_bit(), v(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 0, 0), "memadr");
                for (int i = 0; i < mw; i++)
                    push(1'b0, v(0, 0, 0, 1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0), "memrd_wait");
                push(1'b1, v(0, 0, 0, 1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0), "memrd");
                push(rnd_bit(), v(0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 0, 0), "mem_wb");
            end
            K_ST: begin
                push(rnd_bit(), v(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 0, 0), "memadr");
                for (int i = 0; i < mw; i++)
                    push(1'b0, v(0, 0, 0, 0, 1, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0), "memwr_wait");
                push(1'b1, v(0, 0, 0, 0, 1, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0), "memwr");
            end
            K_CBZ: push(rnd_bit(), v(0, 1, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 1, 0), "cbz");
            K_B:   push(rnd_bit(), v(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0), "br");
            default: push(rnd_bit(), v(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1), "illegal");
        endcase
        Opcode = op;
        Zero   = z;
        foreach (q[i]) begin
            MemReady = q[i].rdy;
            @(negedge CLK);
            check_ctl(q[i].tag, obs, q[i].vec);
            @(posedge CLK);
            #1;
        end
    endtask

    function automatic logic [10:0] pick_opcode(input int kind);
        logic [10:0] op;
        op = 11'($urandom);
        case (kind)
            0: op = 11'b100_0101_1000;
            1: op = 11'b110_0101_1000;
            2: op = 11'b100_0101_0000;
            3: op = 11'b101_0101_0000;
            4: op = 11'b110_1001_1011;
            5: op[10:1] = 10'b10_1100_1000;
            6: op = 11'b111_1100_0010;
            7: op = 11'b111_1100_0000;
            8: op[10:3] = 8'b1011_0100;
            9: op[10:5] = 6'b000101;
            default: op = op;
        endcase
        return op;
    endfunction

    initial begin
        Reset    = 1'b1;
        MemReady = 1'b0;
        Zero     = 1'b0;
        Opcode   = 11'd0;
        #2;
        check_ctl("reset_idle", obs, e_reset());
        MemReady = 1'b1;
        #1;
        check_ctl("reset_rdy_gated", obs, e_reset());
        @(posedge CLK);
        @(posedge CLK);
        #1;
        check_ctl("reset_held", obs, e_reset());
        Reset = 1'b0;
        #1;
        check_ctl("reset_release", obs, e_fetch(1'b1));

        // Directed cases
        run_instr(11'b100_0101_1000, 1'b0, 0, 0);
        run_instr(11'b111_1100_0010, 1'b0, 0, 2);
        run_instr(11'b101_1001_0001, 1'b0, 1, 0);
        run_instr(11'b1011_0100_101, 1'b1, 0, 0);
        run_instr(11'b1011_0100_101, 1'b0, 0, 0);
        run_instr(11'b000_0000_0000, 1'b0, 0, 0);
        run_instr(11'b000_1011_0110, 1'b1, 2, 0);
        run_instr(11'b111_1100_0000, 1'b0, 0, 3);

        // Reset while STUR is stalled in its write
        Opcode   = 11'b111_1100_0000;
        MemReady = 1'b1;
        @(negedge CLK);
        check_ctl("rst_fetch", obs, e_fetch(1'b1));
        @(posedge CLK);
        #1;
        @(negedge CLK);
        check_ctl("rst_decode", obs, v(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 0, 0));
        @(posedge CLK);
        #1;
        @(negedge CLK);
        check_ctl("rst_memadr", obs, v(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 0, 0));
        @(posedge CLK);
        #1;
        MemReady = 1'b0;
        @(negedge CLK);
        check_ctl("rst_memwr_wait", obs, v(0, 0, 0, 0, 1, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0));
        #2;
        Reset = 1'b1;
        #1;
        check_ctl("rst_async", obs, e_reset());
        @(posedge CLK);
        #1;
        check_ctl("rst_async_hold", obs, e_reset());
        Reset = 1'b0;
        #1;
        check_ctl("rst_async_release", obs, e_fetch(1'b0));

        // Random instruction stream
        for (int n = 0; n < 300; n++) begin
            run_instr(pick_opcode($urandom_range(0, 10)), rnd_bit(),
                      $urandom_range(0, 2), $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore FSM sequencing a multi-cycle LEGv8 datapath: one shared ALU, one unified instruction/data memory, register file.
- Sits beside the ALU control decoder and drives its 2-bit ALUOp. Also drives memory strobes, register/PC/IR enables and datapath mux selects.
- Supports ADD, SUB, AND, ORR, ORRI, LSL, LDUR, STUR, CBZ and B, with a memory-ready handshake.

Parameters:
- STATE_W, 4, state register width; must be ≥ 4.

Ports:
- CLK  input  1  rising-edge clock
- Reset  input  1  asynchronous, active-high reset
- Opcode  input  11  instruction bits [31:21] from IR
- Zero  input  1  ALU zero flag
- MemReady  input  1  memory completes the current access this cycle
- PCWrite  output  1  unconditional PC load
- PCWriteCond  output  1  PC load qualified by Zero
- IRWrite  output  1  load instruction register
- MemRead  output  1  memory read strobe
- MemWrite  output  1  memory write strobe
- IorD  output  1  0 = address from PC, 1 = address from ALUOut
- RegWrite  output  1  register file write enable
- MemtoReg  output  1  write-back source: 0 = ALUOut, 1 = MDR
- ALUSrcA  output  1  0 = PC, 1 = register A
- ALUSrcB  output  2  00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = shifted branch offset
- ALUOp  output  2  00 = add, 01 = pass B / compare, 10 = opcode-decoded
- PCSource  output  1  0 = ALU result, 1 = ALUOut
- Illegal  output  1  one-cycle pulse on unrecognised opcode
- State  output  STATE_W  current state, for debug

Behaviour:
- Only the state register is sequential. All outputs are a decode of the current state (Moore), except as noted for FETCH. Outputs not listed for a state are 0.
- Reset asserted: state = FETCH immediately, regardless of clock.
  - While Reset is high, every strobe is 0 (MemRead, MemWrite, RegWrite, PCWrite, IRWrite) and Illegal = 0.
  - Reset mid-instruction abandons that instruction; no partial write occurs after reset asserts.
- FETCH:
  - MemRead = 1, IorD = 0, ALUSrcA = 0, ALUSrcB = 01, ALUOp = 00, PCSource = 0.
  - IRWrite = MemReady and PCWrite = MemReady (only these two outputs depend on an input).
  - Stay in FETCH while MemReady = 0; go to DECODE when MemReady = 1.
- DECODE: ALUSrcA = 0, ALUSrcB = 11, ALUOp = 00 (precompute branch target into ALUOut). Next state by Opcode, first match wins:
  - 111_1100_0010 (LDUR) or 111_1100_0000 (STUR) -> MEMADR
  - Opcode[10:3] = 1011_0100 (CBZ) -> CBZ
  - Opcode[10:5] = 000101 (B) -> BR
  - ADD 100_0101_1000, SUB 110_0101_1000, AND 100_0101_0000, ORR 101_0101_0000, LSL 110_1001_1011 -> EXEC_R
  - Opcode[10:1] = 10_1100_1000 (ORRI) -> EXEC_I
  - anything else -> ILLEGAL
- EXEC_R: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 10 -> ALU_WB.
- EXEC_I: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 10 -> ALU_WB.
- ALU_WB: RegWrite = 1, MemtoReg = 0 -> FETCH.
- MEMADR: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00 -> MEMRD (LDUR) or MEMWR (STUR).
  - Routing uses Opcode[1]. IR is stable because IRWrite = 0 outside FETCH.
- MEMRD: MemRead = 1, IorD = 1. Hold until MemReady = 1 -> MEM_WB.
- MEMWR: MemWrite = 1, IorD = 1. Hold until MemReady = 1 -> FETCH.
  - MemWrite stays high for every wait cycle.
- MEM_WB: RegWrite = 1, MemtoReg = 1 -> FETCH.
- CBZ: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 01, PCWriteCond = 1, PCSource = 1 -> FETCH.
  - PC loads the target only if Zero = 1.
- BR: PCWrite = 1, PCSource = 1 -> FETCH.
- ILLEGAL: Illegal = 1 for exactly one cycle, no writes -> FETCH (instruction skipped, since PC already advanced).
- Unused state encodings -> FETCH on the next edge, all strobes 0.
- Cycle counts with MemReady = 1 throughout:
  - R/I-type: 4 cycles
  - LDUR: 5 cycles
  - STUR: 4 cycles
  - CBZ, B, illegal: 3 cycles
  - Each MemReady = 0 cycle adds one cycle in the waiting state.

Test Plan:
- Reset pulse mid-MEMWR with MemReady = 0 -> State = FETCH asynchronously before the next edge, MemWrite = 0 immediately; after release, FETCH with MemRead = 1.
- Opcode 100_0101_1000 (ADD), MemReady = 1 -> FETCH, DECODE, EXEC_R (ALUOp = 10, ALUSrcB = 00), ALU_WB (RegWrite = 1) -> back in FETCH on cycle 5.
- Opcode 111_1100_0010 (LDUR), MemReady low for 2 cycles in MEMRD -> MemRead = 1 and IorD = 1 held for 3 cycles, then MEM_WB with MemtoReg = 1; total 7 cycles.
- Opcode 101_1001_0001 (ORRI, bit 0 don't-care) -> EXEC_I with ALUSrcB = 10, ALUOp = 10.
- Opcode 1011_0100_xxx (CBZ): Zero = 1 -> PCWriteCond = 1 sampled with PCSource = 1; repeat with Zero = 0 -> identical outputs, and PCWrite never asserts in the CBZ state.
- Opcode 000_0000_0000 -> DECODE -> ILLEGAL, Illegal high exactly 1 cycle, RegWrite/MemWrite = 0, then FETCH.
